// File: rtl/ice51_pkg.sv
// Shared types and constants for the ice51 boot loader and its UART receiver.
package ice51_pkg;

   localparam int CODE_ADDR_W = 9;
   localparam int CODE_DEPTH  = 512;

   typedef enum logic [1:0] {HDR_HI, HDR_LO, LOAD, RUN} ld_state_t;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   // Image length is acceptable when non-zero and fits in code memory.
   function automatic logic len_ok(input logic [15:0] len, input logic [16:0] depth);
      return (len != 16'd0) && ({1'b0, len} <= depth);
   endfunction

endpackage

// File: rtl/ice51_loader_if.sv
// Code memory write port driven by the boot loader.
interface ice51_loader_if #(parameter int ADDR_W = ice51_pkg::CODE_ADDR_W);
   logic              code_wr;
   logic [ADDR_W-1:0] code_addr;
   logic [7:0]        code_data;

   modport master (output code_wr, code_addr, code_data);
   modport slave  (input  code_wr, code_addr, code_data);
endinterface

// File: rtl/ice51_uart_rx.sv
// 8N1 UART receiver: synchroniser, bit timer and deserialiser with registered
// single-cycle byte/frame-error pulses.
module ice51_uart_rx
   import ice51_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       i_clk,
   input  logic       i_nrst,
   input  logic       i_rx,
   output logic       o_byte_valid,
   output logic [7:0] o_byte,
   output logic       o_frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   logic [1:0]    sync_q, sync_d;
   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          rx;

   assign rx = sync_q[1];

   always_comb begin
      sync_d  = {sync_q[0], i_rx};
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx) begin
               state_d = START;
               bit_d   = '0;
            end
         end
         // Mid-start-bit check rejects short glitches on the idle line.
         START: begin
            if (cnt_q == HALF) begin
               cnt_d   = '0;
               state_d = rx ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               shreg_d = {rx, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               valid_d = rx;
               ferr_d  = !rx;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         sync_q  <= 2'b11;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign o_byte_valid = valid_q;
   assign o_byte       = shreg_q;
   assign o_frame_err  = ferr_q;

endmodule

// File: rtl/ice51_loader.sv
// UART boot loader: takes a 16-bit big-endian length header plus image bytes,
// writes them to code memory from address 0, then releases the core reset.
module ice51_loader
   import ice51_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int ADDR_W       = CODE_ADDR_W,
   parameter int DEPTH        = CODE_DEPTH
) (
   input  logic           i_clk,
   input  logic           i_nrst,
   input  logic           i_uart_rx,
   ice51_loader_if.master code,
   output logic           o_core_nrst,
   output logic           o_frame_err
);

   logic       byte_valid;
   logic [7:0] rx_byte;

   ice51_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .i_clk        (i_clk),
      .i_nrst       (i_nrst),
      .i_rx         (i_uart_rx),
      .o_byte_valid (byte_valid),
      .o_byte       (rx_byte),
      .o_frame_err  (o_frame_err)
   );

   ld_state_t         state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [7:0]        wd_q, wd_d;
   logic              nrst_q, nrst_d;
   logic [16:0]       written;

   // Byte count after this write; wide enough that addr never has to wrap.
   assign written = 17'(addr_q) + 17'd1;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      addr_d  = addr_q;
      wr_d    = 1'b0;
      wa_d    = wa_q;
      wd_d    = wd_q;
      nrst_d  = (state_q == RUN);
      if (byte_valid) begin
         case (state_q)
            HDR_HI: begin
               len_d   = {rx_byte, 8'h00};
               state_d = HDR_LO;
            end
            HDR_LO: begin
               len_d = {len_q[15:8], rx_byte};
               if (len_ok({len_q[15:8], rx_byte}, 17'(DEPTH))) begin
                  addr_d  = '0;
                  state_d = LOAD;
               end else begin
                  state_d = HDR_HI;
               end
            end
            LOAD: begin
               wr_d = 1'b1;
               wa_d = addr_q;
               wd_d = rx_byte;
               if (written == {1'b0, len_q}) state_d = RUN;
               else                          addr_d  = addr_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q <= HDR_HI;
         len_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
         nrst_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         nrst_q  <= nrst_d;
      end
   end

   assign code.code_wr   = wr_q;
   assign code.code_addr = wa_q;
   assign code.code_data = wd_q;
   assign o_core_nrst    = nrst_q;

endmodule

// File: tb/tb_ice51_loader.sv
// Bench for ice51_loader: serial images against a stream-level loader model.
module tb_ice51_loader;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   logic core_nrst, ferr;

   ice51_loader_if #(.ADDR_W(9)) cif ();

   ice51_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(9), .DEPTH(512)) dut (
      .i_clk       (clk),
      .i_nrst      (rst_n),
      .i_uart_rx   (rx),
      .code        (cif),
      .o_core_nrst (core_nrst),
      .o_frame_err (ferr)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Observed write log and event timing, sampled on the falling edge.
   int   cyc = 0, last_wr_cyc = -1, rise_cyc = -1, ferr_cnt = 0, dbl_wr = 0;
   logic prev_wr = 1'b0, prev_nrst = 1'b0;
   int   wl_addr[$];
   int   wl_data[$];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (cif.code_wr) begin
         wl_addr.push_back(int'(cif.code_addr));
         wl_data.push_back(int'(cif.code_data));
         last_wr_cyc <= cyc;
         if (prev_wr) dbl_wr <= dbl_wr + 1;
      end
      if (core_nrst && !prev_nrst) rise_cyc <= cyc;
      if (ferr) ferr_cnt <= ferr_cnt + 1;
      prev_wr   <= cif.code_wr;
      prev_nrst <= core_nrst;
   end

   // Reference model: consumes whole received bytes, predicts writes and run.
   int ex_addr[$];
   int ex_data[$];
   bit m_have_hi, m_in_img, m_run;
   int m_hi, m_len, m_cnt;

   task automatic model_reset();
      m_have_hi = 0; m_in_img = 0; m_run = 0;
      m_hi = 0; m_len = 0; m_cnt = 0;
      ex_addr.delete(); ex_data.delete();
   endtask

   task automatic model_feed(input int b);
      if (m_run) return;
      if (m_in_img) begin
         ex_addr.push_back(m_cnt);
         ex_data.push_back(b);
         m_cnt++;
         if (m_cnt == m_len) m_run = 1;
      end else if (!m_have_hi) begin
         m_hi = b; m_have_hi = 1;
      end else begin
         m_have_hi = 0;
         m_len = m_hi * 256 + b;
         if (m_len >= 1 && m_len <= 512) begin
            m_in_img = 1; m_cnt = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_hi);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_hi;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      if (!stop_hi) repeat (2 * CPB) @(negedge clk);
      repeat (2) @(negedge clk);
   endtask

   task automatic feed(input int b);
      model_feed(b);
      send_byte(8'(b), 1'b1);
   endtask

   task automatic check_outputs_reset(input string tag);
      chk({tag, ".wr"},   32'(cif.code_wr),   32'd0);
      chk({tag, ".addr"}, 32'(cif.code_addr), 32'd0);
      chk({tag, ".data"}, 32'(cif.code_data), 32'd0);
      chk({tag, ".nrst"}, 32'(core_nrst),     32'd0);
      chk({tag, ".ferr"}, 32'(ferr),          32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      wl_addr.delete(); wl_data.delete();
   endtask

   task automatic check_writes(input string tag);
      chk($sformatf("%s.count", tag), 32'(wl_addr.size()), 32'(ex_addr.size()));
      for (int i = 0; i < ex_addr.size() && i < wl_addr.size(); i++) begin
         chk($sformatf("%s.addr[%0d]", tag, i), 32'(wl_addr[i]), 32'(ex_addr[i]));
         chk($sformatf("%s.data[%0d]", tag, i), 32'(wl_data[i]), 32'(ex_data[i]));
      end
      chk($sformatf("%s.core_nrst", tag), 32'(core_nrst), 32'(m_run));
      if (m_run) chk($sformatf("%s.rise", tag), 32'(rise_cyc), 32'(last_wr_cyc + 1));
      chk($sformatf("%s.single_pulse", tag), 32'(dbl_wr), 32'd0);
      wl_addr.delete(); wl_data.delete();
      ex_addr.delete(); ex_data.delete();
   endtask

   initial begin
      int fe0, n;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs_reset("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic three-byte image.
      feed(8'h00); feed(8'h03);
      feed(8'hA5); feed(8'h5A); feed(8'hFF);
      check_writes("t1");

      // Traffic after RUN is ignored.
      feed(int'($urandom_range(0, 255))); feed(int'($urandom_range(0, 255)));
      check_writes("t6");

      // Zero and oversize lengths are rejected, then a one-byte image.
      do_reset();
      feed(8'h00); feed(8'h00);
      feed(8'h02); feed(8'h01);
      chk("t3.rejected", 32'(wl_addr.size()), 32'd0);
      feed(8'h00); feed(8'h01); feed(8'h42);
      check_writes("t3");

      // Framing error mid-load loses the byte without moving the address.
      do_reset();
      feed(8'h00); feed(8'h03);
      feed(int'($urandom_range(0, 255)));
      fe0 = ferr_cnt;
      send_byte(8'($urandom_range(0, 255)), 1'b0);
      chk("t4.ferr", 32'(ferr_cnt), 32'(fe0 + 1));
      chk("t4.addr_hold", 32'(cif.code_addr), 32'd0);
      chk("t4.no_write", 32'(wl_addr.size()), 32'd1);
      feed(int'($urandom_range(0, 255))); feed(int'($urandom_range(0, 255)));
      check_writes("t4");

      // Short glitch on idle line, then reset part-way through a load.
      do_reset();
      fe0 = ferr_cnt;
      rx = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("t5.glitch_ferr", 32'(ferr_cnt), 32'(fe0));
      chk("t5.glitch_wr", 32'(wl_addr.size()), 32'd0);
      n = int'($urandom_range(3, 6));
      feed(0); feed(n);
      feed(int'($urandom_range(0, 255))); feed(int'($urandom_range(0, 255)));
      rst_n = 1'b0;
      @(negedge clk);
      check_outputs_reset("t5.midreset");
      do_reset();
      feed(0); feed(n);
      for (int i = 0; i < n; i++) feed(int'($urandom_range(0, 255)));
      check_writes("t5.reload");

      // Full-depth image ends at the last address.
      do_reset();
      feed(8'h02); feed(8'h00);
      for (int i = 0; i < 512; i++) feed(i & 8'hFF);
      chk("t2.last_addr", 32'(cif.code_addr), 32'd511);
      chk("t2.last_data", 32'(cif.code_data), 32'hFF);
      check_writes("t2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
